// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU among NUM_REQ requesters.
// Optional macro ALU_SHARE_ARB_PRIO_EN makes requester 0 a fixed high-priority requester.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ALU_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [4*NUM_REQ-1:0]   req_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_sel,
    input  logic [7:0]             alu_out,
    input  logic                   alu_carry,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [7:0]             rsp_data,
    output logic                   rsp_carry,
    output logic                   rsp_err,
    output logic                   busy
);
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 3;
    localparam int unsigned MAXREQ = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [OW-1:0]   alu_sel_q, alu_sel_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [MAXREQ-1:0]    valid_ext;
    logic [MAXREQ*DW-1:0] a_ext;
    logic [MAXREQ*DW-1:0] b_ext;
    logic [MAXREQ*OW-1:0] op_ext;
    logic                 grant_found;
    logic [IW-1:0]        grant_idx;
    logic [DW-1:0]        grant_a;
    logic [DW-1:0]        grant_b;
    logic [OW-1:0]        grant_op;
    logic                 grant_err;
    logic [IW-1:0]        next_ptr;

    assign valid_ext = MAXREQ'(req_valid);
    assign a_ext     = (MAXREQ*DW)'(req_a);
    assign b_ext     = (MAXREQ*DW)'(req_b);
    assign op_ext    = (MAXREQ*OW)'(req_op);

    // Winner search: pointer first, then upward with wrap
    always_comb begin
        logic [IW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
`ifdef ALU_SHARE_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IW'((32'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && valid_ext[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign grant_a   = a_ext[{grant_idx, 3'b000} +: DW];
    assign grant_b   = b_ext[{grant_idx, 3'b000} +: DW];
    assign grant_op  = op_ext[{grant_idx, 2'b00} +: OW];
    assign grant_err = (grant_op > 4'd8) || (grant_op == 4'd3 && grant_b == '0);
    assign next_ptr  = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);

    // Next-state, handshake and datapath control
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    gid_d     = grant_idx;
                    if (grant_err) begin
                        state_d     = RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_idx;
                        rsp_data_d  = '0;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        alu_a_d   = grant_a;
                        alu_b_d   = grant_b;
                        alu_sel_d = grant_op;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(ALU_LATENCY);
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d     = RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gid_q;
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_err_d   = 1'b0;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    alu_sel_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = '0;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_err_d   = 1'b0;
`ifdef ALU_SHARE_ARB_PRIO_EN
                    if (gid_q != '0) begin
                        ptr_d = next_ptr;
                    end
`else
                    ptr_d = next_ptr;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // Accept is combinational, so gate it while reset holds the state
        if (reset) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model; includes a behavioural pipelined ALU.
module tb_alu_share_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 2;

    logic                 clock;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0] req_op;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [3:0]           alu_sel;
    logic [7:0]           alu_out;
    logic                 alu_carry;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_carry;
    logic                 rsp_err;
    logic                 busy;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            4'd0: return 9'(a) + 9'(b);
            4'd1: return 9'(a) - 9'(b);
            4'd2: return {|p[15:8], p[7:0]};
            4'd3: return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
            4'd4: return {1'b0, a & b};
            4'd5: return {1'b0, a | b};
            4'd6: return {1'b0, a ^ b};
            4'd7: return {1'b0, a << b[2:0]};
            4'd8: return {1'b0, a >> b[2:0]};
            default: return 9'd0;
        endcase
    endfunction

    logic [8:0] alu_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) alu_pipe[i] = 9'd0;
    always @(posedge clock) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_sel);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_carry, alu_out} = alu_pipe[LAT-1];

    // Requester-side drive state
    logic       v   [NUM_REQ];
    logic [7:0] ra  [NUM_REQ];
    logic [7:0] rb  [NUM_REQ];
    logic [3:0] rop [NUM_REQ];
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = v[i];
            req_a[8*i +: 8]    = ra[i];
            req_b[8*i +: 8]    = rb[i];
            req_op[4*i +: 4]   = rop[i];
        end
    end

    // Reference model: one transaction at a time, described by its grant cycle
    int                 cyc = 0;
    logic [NUM_REQ-1:0] acc_q = '0;
    bit                 m_idle = 1'b1;
    int                 m_ptr = 0;
    int                 m_g, m_t, m_rsp_t;
    logic [7:0]         m_a, m_b, m_data;
    logic [3:0]         m_op;
    logic               m_err, m_carry;
    int                 grant_log[$];
    int                 rsp_count = 0;
    logic [2:0]         last_id;
    logic [7:0]         last_data;
    logic               last_err;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] vv, input int ptr);
`ifdef ALU_SHARE_ARB_PRIO_EN
        if (vv[0]) return 0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (vv[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [19:0] exp_alu;
        logic [8:0]  r;
        cyc++;
        if (reset) begin
            m_idle = 1'b1;
            m_ptr  = 0;
            acc_q  = '0;
        end else begin
            acc_q = req_ready & req_valid;
            for (int k = 0; k < NUM_REQ; k++) if (acc_q[k]) grant_log.push_back(k);
            if (rsp_valid && rsp_ready) begin
                last_id   = rsp_id;
                last_data = rsp_data;
                last_err  = rsp_err;
            end
            if (m_idle) begin
                g       = rr_pick(req_valid, m_ptr);
                exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
                check_eq("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
                check_eq("busy_idle", 32'(busy), 32'(0));
                check_eq("rsp_valid_idle", 32'(rsp_valid), 32'(0));
                check_eq("alu_in_idle", {alu_a, alu_b, alu_sel}, 32'(0));
                if (g >= 0) begin
                    m_g    = g;
                    m_a    = ra[g];
                    m_b    = rb[g];
                    m_op   = rop[g];
                    m_t    = cyc;
                    m_err  = (m_op > 4'd8) || (m_op == 4'd3 && m_b == 8'd0);
                    m_rsp_t = m_err ? cyc + 1 : cyc + 2 + LAT;
                    r      = m_err ? 9'd0 : alu_fn(m_a, m_b, m_op);
                    {m_carry, m_data} = r;
                    m_idle = 1'b0;
                end
            end else begin
                check_eq("req_ready_busy", 32'(req_ready), 32'(0));
                check_eq("busy", 32'(busy), 32'(1));
                exp_alu = (!m_err && cyc >= m_t + 1 && cyc <= m_t + 1 + LAT) ? {m_a, m_b, m_op} : 20'd0;
                check_eq("alu_in", {alu_a, alu_b, alu_sel}, 32'(exp_alu));
                if (cyc >= m_rsp_t) begin
                    check_eq("rsp_fields", {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err},
                             {1'b1, 3'(m_g), m_data, m_carry, m_err});
                    if (rsp_ready) begin
                        m_idle = 1'b1;
                        rsp_count++;
`ifdef ALU_SHARE_ARB_PRIO_EN
                        if (m_g != 0) m_ptr = (m_g + 1) % NUM_REQ;
`else
                        m_ptr = (m_g + 1) % NUM_REQ;
`endif
                    end
                end else begin
                    check_eq("rsp_valid_early", 32'(rsp_valid), 32'(0));
                end
            end
        end
    end

    // Stimulus control
    int mode    = 0;    // 0: accepted requests drop, 1: random traffic, 2: continuous adds
    int new_pct = 30;
    int rdy_pct = -1;   // -1: rsp_ready driven directly

    task automatic new_req(input int i, input bit add_only);
        int r;
        v[i]  = 1'b1;
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        r     = $urandom_range(99);
        if (add_only || r < 65) rop[i] = add_only ? 4'd0 : 4'($urandom_range(8));
        else if (r < 82) begin
            rop[i] = 4'd3;
            if ($urandom_range(1) == 0) rb[i] = 8'd0;
        end else rop[i] = 4'($urandom_range(15, 9));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc_q[i]) v[i] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!v[i] && mode == 1 && $urandom_range(99) < new_pct) new_req(i, 1'b0);
            if (!v[i] && mode == 2) new_req(i, 1'b1);
        end
        if (rdy_pct >= 0) rsp_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        v[i] = 1'b1; ra[i] = a; rb[i] = b; rop[i] = op;
    endtask

    task automatic drop_all();
        for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(0));
        check_eq({tag, "_alu"}, {alu_a, alu_b, alu_sel}, 32'(0));
        check_eq({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err}, 32'(0));
        check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    function automatic int glog(input int k);
        if (k < 0 || k >= grant_log.size()) return -1;
        return grant_log[k];
    endfunction

    int exp_rr[5];
    bit found;

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        set_req(1, 8'h11, 8'h22, 4'd0);
        #12;
        check_outputs_zero("reset");
        drop_all();
        @(posedge clock);
        #1 reset = 1'b0;

        // Single add from requester 1
        set_req(1, 8'h05, 8'h03, 4'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check_eq("t1_id", 32'(last_id), 32'(1));
        check_eq("t1_data", 32'(last_data), 32'h08);
        check_eq("t1_err", 32'(last_err), 32'(0));

        // Four continuous requesters from pointer 0
        do_reset();
        grant_log.delete();
        mode = 2;
        rdy_pct = 100;
        for (int k = 0; k < 60 && grant_log.size() < 5; k++) step();
        mode = 0;
        drop_all();
        for (int k = 0; k < 8; k++) step();
`ifdef ALU_SHARE_ARB_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++) check_eq($sformatf("rr_grant%0d", k), 32'(glog(k)), 32'(exp_rr[k]));

        // Divide by zero and illegal op are rejected
        rdy_pct = -1;
        rsp_ready = 1'b1;
        set_req(2, 8'h40, 8'h00, 4'd3);
        for (int k = 0; k < 4; k++) step();
        check_eq("div0_err", 32'(last_err), 32'(1));
        check_eq("div0_data", 32'(last_data), 32'(0));
        check_eq("div0_id", 32'(last_id), 32'(2));
        set_req(0, 8'h12, 8'h34, 4'hC);
        for (int k = 0; k < 4; k++) step();
        check_eq("illop_err", 32'(last_err), 32'(1));
        check_eq("illop_id", 32'(last_id), 32'(0));

        // Backpressure with requester 3 pending
        grant_log.delete();
        rsp_ready = 1'b0;
        set_req(0, 8'h81, 8'h90, 4'd0);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (!m_idle && cyc + 1 >= m_rsp_t) found = 1'b1;
        end
        check_eq("bp_reach_respond", 32'(found), 32'(1));
        set_req(3, 8'h07, 8'h09, 4'd0);
        for (int k = 0; k < 5; k++) step();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check_eq("bp_first", 32'(glog(0)), 32'(0));
        check_eq("bp_second", 32'(glog(1)), 32'(3));

        // Reset during WAIT, after requester 2 moved the pointer to 3
        set_req(2, 8'h01, 8'h02, 4'd0);
        for (int k = 0; k < 8; k++) step();
        set_req(1, 8'h21, 8'h05, 4'd2);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (!m_idle && !m_err && cyc == m_t + 1) found = 1'b1;
        end
        check_eq("reach_wait", 32'(found), 32'(1));
        reset = 1'b1;
        #1;
        check_outputs_zero("rst_wait");
        drop_all();
        @(posedge clock);
        #1 reset = 1'b0;
        grant_log.delete();
        set_req(2, 8'h0A, 8'h0B, 4'd0);
        set_req(3, 8'h0C, 8'h0D, 4'd0);
        for (int k = 0; k < 8; k++) step();
        check_eq("post_rst_grant", 32'(glog(0)), 32'(2));
        drop_all();
        for (int k = 0; k < 8; k++) step();

        // Random traffic with random backpressure
        rsp_count = 0;
        mode = 1;
        new_pct = 30;
        rdy_pct = 70;
        for (int k = 0; k < 3000; k++) step();
        mode = 0;
        rdy_pct = 100;
        for (int k = 0; k < 60; k++) step();
        check_eq("rand_rsp_min", 32'(rsp_count >= 100), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
